// File: rtl/boot_rom_copier.sv
// Boot ROM to instruction-RAM copier with a running additive checksum.
// Alternates a one-cycle ROM read with a req/gnt RAM write per word.
module boot_rom_copier #(
  parameter int ROM_AW    = 10,
  parameter int ROM_WORDS = 800,
  parameter int LEN_W     = 11
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_i,
  input  logic [ROM_AW-1:0] src_i,
  input  logic [31:0]       dst_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_a_o,
  input  logic [31:0]       rom_q_i,
  output logic              ram_req_o,
  output logic [31:0]       ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic [3:0]        ram_be_o,
  input  logic              ram_gnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       checksum_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state, state_n;
  logic [ROM_AW-1:0] src, rom_a;
  logic [31:0]       dst, sum;
  logic [LEN_W-1:0]  rem;
  logic              err;
  logic [LEN_W:0]    end_w;
  logic              range_bad, go, wr_fire;

  // End of range at LEN_W+1 bits so src+len cannot wrap
  assign end_w     = (LEN_W+1)'(src_i) + (LEN_W+1)'(len_i);
  assign range_bad = end_w > (LEN_W+1)'(ROM_WORDS);
  assign go        = (state == IDLE) && start_i;
  assign wr_fire   = (state == WR) && ram_gnt_i;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start_i)
              state_n = (range_bad || len_i == '0) ? DONE : RD;
      RD:   state_n = WR;
      WR:   if (ram_gnt_i)
              state_n = (rem == LEN_W'(1)) ? DONE : RD;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      src   <= '0;
      rom_a <= '0;
      dst   <= '0;
      rem   <= '0;
      sum   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (go) begin
        src <= src_i;
        dst <= dst_i;
        rem <= len_i;
        sum <= '0;
        err <= range_bad;
      end
      // Remember the last issued address so it holds while idle
      if (state == RD)
        rom_a <= src;
      if (wr_fire) begin
        sum <= sum + rom_q_i;
        src <= src + ROM_AW'(1);
        dst <= dst + 32'd4;
        rem <= rem - LEN_W'(1);
      end
    end
  end

  assign rom_csn_o   = (state != RD);
  assign rom_a_o     = (state == RD) ? src : rom_a;
  assign ram_req_o   = (state == WR);
  assign ram_addr_o  = (state == WR) ? dst : 32'd0;
  assign ram_wdata_o = (state == WR) ? rom_q_i : 32'd0;
  assign ram_be_o    = 4'hF;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign err_o       = err;
  assign checksum_o  = sum;

endmodule

// File: tb/tb_boot_rom_copier.sv
// Directed bench for boot_rom_copier with a behavioural ROM and
// a RAM grant driver that can tie, stall or block gnt.
module tb_boot_rom_copier;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start_i;
  logic [9:0]  src_i;
  logic [31:0] dst_i;
  logic [10:0] len_i;
  logic        rom_csn_o;
  logic [9:0]  rom_a_o;
  logic [31:0] rom_q;
  logic        ram_req_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_be_o;
  logic        gnt;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] checksum_o;

  int n_tests = 0;
  int n_fail  = 0;
  int gmode   = 0;
  int gcnt    = 0;
  int n_wr, n_csn, n_unstable;
  int cyc;
  logic [31:0] wa [8];
  logic [31:0] wd [8];
  logic        prev_req;
  logic [31:0] prev_a, prev_d;

  boot_rom_copier dut (
    .CLK         (CLK),
    .RST         (RST),
    .start_i     (start_i),
    .src_i       (src_i),
    .dst_i       (dst_i),
    .len_i       (len_i),
    .rom_csn_o   (rom_csn_o),
    .rom_a_o     (rom_a_o),
    .rom_q_i     (rom_q),
    .ram_req_o   (ram_req_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_be_o    (ram_be_o),
    .ram_gnt_i   (gnt),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .checksum_o  (checksum_o)
  );

  always #5 CLK = ~CLK;

  // ROM: mem[i] = i * 0x01010101, Q registered when csn low
  always @(posedge CLK) begin
    if (!rom_csn_o)
      rom_q <= {22'd0, rom_a_o} * 32'h0101_0101;
  end

  // gmode 0: gnt high; 1: 3 stalled edges per request; 2: gnt low
  always @(negedge CLK) begin
    if (gmode == 0) begin
      gnt = 1'b1;
    end else if (gmode == 2) begin
      gnt = 1'b0;
    end else if (!ram_req_o) begin
      gcnt = 0;
      gnt  = 1'b0;
    end else if (gcnt < 3) begin
      gcnt = gcnt + 1;
      gnt  = 1'b0;
    end else begin
      gnt = 1'b1;
    end
  end

  always @(posedge CLK) begin
    if (!RST) begin
      if (!rom_csn_o)
        n_csn = n_csn + 1;
      if (ram_req_o && prev_req &&
          (ram_addr_o != prev_a || ram_wdata_o != prev_d))
        n_unstable = n_unstable + 1;
      prev_req = ram_req_o && !gnt;
      prev_a   = ram_addr_o;
      prev_d   = ram_wdata_o;
      if (ram_req_o && gnt) begin
        if (n_wr < 8) begin
          wa[n_wr] = ram_addr_o;
          wd[n_wr] = ram_wdata_o;
        end
        n_wr = n_wr + 1;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [9:0] s,
                       input logic [31:0] d,
                       input logic [10:0] l);
    @(negedge CLK);
    src_i   = s;
    dst_i   = d;
    len_i   = l;
    start_i = 1'b1;
    @(posedge CLK);
    #1 start_i = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] s,
                          input logic [31:0] d,
                          input logic [10:0] l);
    @(negedge CLK);
    n_wr       = 0;
    n_csn      = 0;
    n_unstable = 0;
    prev_req   = 1'b0;
    pulse(s, d, l);
  endtask

  // cycle 1 is the cycle right after the start edge
  task automatic wait_done(output int c);
    c = 1;
    while (!done_o && c < 200) begin
      @(posedge CLK);
      #1 c = c + 1;
    end
    check("done_seen", {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    RST     = 1'b1;
    start_i = 1'b0;
    src_i   = '0;
    dst_i   = '0;
    len_i   = '0;
    gnt     = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_csn",   {31'd0, rom_csn_o}, 32'd1);
    check("rst_rom_a", {22'd0, rom_a_o}, 32'd0);
    check("rst_req",   {31'd0, ram_req_o}, 32'd0);
    check("rst_addr",  ram_addr_o, 32'd0);
    check("rst_wdata", ram_wdata_o, 32'd0);
    check("rst_busy",  {31'd0, busy_o}, 32'd0);
    check("rst_done",  {31'd0, done_o}, 32'd0);
    check("rst_err",   {31'd0, err_o}, 32'd0);
    check("rst_cks",   checksum_o, 32'd0);
    check("be",        {28'd0, ram_be_o}, 32'hF);
    @(negedge CLK);
    RST = 1'b0;

    // basic 4-word copy, gnt tied high
    do_start(10'd0, 32'h0, 11'd4);
    wait_done(cyc);
    check("t1_cycle", cyc, 32'd9);
    check("t1_cks",   checksum_o, 32'h0606_0606);
    check("t1_err",   {31'd0, err_o}, 32'd0);
    check("t1_nwr",   n_wr, 32'd4);
    check("t1_ncsn",  n_csn, 32'd4);
    check("t1_a0", wa[0], 32'h0);
    check("t1_a1", wa[1], 32'h4);
    check("t1_a2", wa[2], 32'h8);
    check("t1_a3", wa[3], 32'hC);
    check("t1_d0", wd[0], 32'h0000_0000);
    check("t1_d1", wd[1], 32'h0101_0101);
    check("t1_d2", wd[2], 32'h0202_0202);
    check("t1_d3", wd[3], 32'h0303_0303);
    @(posedge CLK);
    #1;
    check("t1_idle_busy",  {31'd0, busy_o}, 32'd0);
    check("t1_idle_csn",   {31'd0, rom_csn_o}, 32'd1);
    check("t1_idle_rom_a", {22'd0, rom_a_o}, 32'd3);
    check("t1_cks_hold",   checksum_o, 32'h0606_0606);

    // 3 stalled edges per write
    gmode = 1;
    do_start(10'd10, 32'h100, 11'd2);
    wait_done(cyc);
    check("t2_cycle",  cyc, 32'd11);
    check("t2_cks",    checksum_o, 32'h1515_1515);
    check("t2_ncsn",   n_csn, 32'd2);
    check("t2_stable", n_unstable, 32'd0);
    check("t2_nwr",    n_wr, 32'd2);
    check("t2_a0", wa[0], 32'h100);
    check("t2_a1", wa[1], 32'h104);
    check("t2_d0", wd[0], 32'h0A0A_0A0A);
    check("t2_d1", wd[1], 32'h0B0B_0B0B);
    gmode = 0;

    // out-of-range request
    do_start(10'd798, 32'h0, 11'd3);
    wait_done(cyc);
    check("t3_cycle", cyc, 32'd1);
    check("t3_err",   {31'd0, err_o}, 32'd1);
    check("t3_ncsn",  n_csn, 32'd0);
    check("t3_nwr",   n_wr, 32'd0);
    @(posedge CLK);
    #1 check("t3_err_hold", {31'd0, err_o}, 32'd1);

    // zero length clears err
    do_start(10'd5, 32'h0, 11'd0);
    wait_done(cyc);
    check("t4_cycle", cyc, 32'd1);
    check("t4_err",   {31'd0, err_o}, 32'd0);
    check("t4_cks",   checksum_o, 32'd0);
    check("t4_ncsn",  n_csn, 32'd0);
    check("t4_nwr",   n_wr, 32'd0);

    // start while busy is ignored
    do_start(10'd0, 32'h200, 11'd4);
    repeat (2) @(posedge CLK);
    pulse(10'd100, 32'h0, 11'd2);
    wait_done(cyc);
    check("t5_nwr", n_wr, 32'd4);
    check("t5_cks", checksum_o, 32'h0606_0606);
    check("t5_a3",  wa[3], 32'h20C);
    repeat (4) @(posedge CLK);
    #1 check("t5_no_restart", {31'd0, busy_o}, 32'd0);

    // async reset during a stalled write
    gmode = 2;
    do_start(10'd0, 32'h0, 11'd4);
    for (int i = 0; i < 10 && !ram_req_o; i++) begin
      @(posedge CLK);
      #1;
    end
    check("t6_req_up", {31'd0, ram_req_o}, 32'd1);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    check("t6_req",   {31'd0, ram_req_o}, 32'd0);
    check("t6_busy",  {31'd0, busy_o}, 32'd0);
    check("t6_csn",   {31'd0, rom_csn_o}, 32'd1);
    check("t6_rom_a", {22'd0, rom_a_o}, 32'd0);
    check("t6_addr",  ram_addr_o, 32'd0);
    check("t6_wdata", ram_wdata_o, 32'd0);
    check("t6_cks",   checksum_o, 32'd0);
    @(negedge CLK);
    RST   = 1'b0;
    gmode = 0;
    do_start(10'd799, 32'h40, 11'd1);
    wait_done(cyc);
    check("t6_cycle", cyc, 32'd3);
    check("t6_nwr",   n_wr, 32'd1);
    check("t6_a0",    wa[0], 32'h40);
    check("t6_d0",    wd[0], 32'h2222_221F);
    check("t6_cks2",  checksum_o, 32'h2222_221F);

    // destination address wrap
    do_start(10'd0, 32'hFFFF_FFFC, 11'd2);
    wait_done(cyc);
    check("t7_nwr", n_wr, 32'd2);
    check("t7_a0",  wa[0], 32'hFFFF_FFFC);
    check("t7_a1",  wa[1], 32'h0000_0000);
    check("t7_cks", checksum_o, 32'h0101_0101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
